// File: rtl/updown_counter_sequencer.sv
// updown_counter_sequencer: drives an up/down counter through a triangle profile between captured limits
module updown_counter_sequencer #(
  parameter int W = 8,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              start,
  input  logic              abort,
  input  logic [W-1:0]      start_val,
  input  logic [W-1:0]      hi_lim,
  input  logic [W-1:0]      lo_lim,
  input  logic [PASS_W-1:0] n_passes,
  input  logic [W-1:0]      cnt_q,
  output logic [W-1:0]      cnt_d,
  output logic              cnt_load,
  output logic              cnt_up_down,
  output logic              cnt_clear_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PASS_W-1:0] pass_cnt
);
  typedef enum logic [2:0] {CLR, IDLE, LOAD, UP, DOWN, DONE} state_t;
  state_t state, state_nx;
  logic [W-1:0] sv_r, hi_r, lo_r;
  logic [PASS_W-1:0] np_r;
  logic valid, go, at_lo, last;
  assign valid = lo_lim < hi_lim && lo_lim <= start_val && start_val <= hi_lim;
  assign go    = state == IDLE && start && !abort;
  assign at_lo = cnt_q == lo_r;
  assign last  = np_r != '0 && PASS_W'(pass_cnt + 1'b1) == np_r;
  // The counter has no enable, so every non-counting state reloads cnt_q to hold.
  always_comb begin
    state_nx    = state;
    cnt_load    = 1'b1;
    cnt_d       = cnt_q;
    cnt_up_down = 1'b0;
    cnt_clear_n = 1'b1;
    case (state)
      CLR: begin
        cnt_clear_n = 1'b0;
        cnt_load    = 1'b0;
        cnt_d       = '0;
        state_nx    = IDLE;
      end
      IDLE: state_nx = go && valid ? LOAD : IDLE;
      LOAD: begin
        cnt_d    = sv_r;
        state_nx = UP;
      end
      UP: begin
        cnt_load    = 1'b0;
        cnt_up_down = cnt_q != hi_r;
        state_nx    = cnt_q == hi_r ? DOWN : UP;
      end
      DOWN: begin
        cnt_load    = at_lo && last;
        cnt_up_down = at_lo && !last;
        state_nx    = at_lo ? (last ? DONE : UP) : DOWN;
      end
      DONE: state_nx = IDLE;
      default: state_nx = CLR;
    endcase
    if (abort && state != CLR) begin
      state_nx    = IDLE;
      cnt_load    = 1'b1;
      cnt_d       = cnt_q;
      cnt_up_down = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state    <= CLR;
      pass_cnt <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      sv_r     <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      np_r     <= '0;
    end else begin
      state <= state_nx;
      busy  <= state_nx inside {LOAD, UP, DOWN};
      done  <= state_nx == DONE;
      err   <= go && !valid;
      if (go && valid) begin
        sv_r     <= start_val;
        hi_r     <= hi_lim;
        lo_r     <= lo_lim;
        np_r     <= n_passes;
        pass_cnt <= '0;
      end else if (state == DOWN && at_lo && !abort) begin
        pass_cnt <= pass_cnt + 1'b1;
      end
    end
  end
endmodule
